// File: rtl/reg_file_8x32_pkg.sv
// reg_file_8x32_pkg: shared sizes and the hardwired-zero register index for the register file.
package reg_file_8x32_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 3'd0;
endpackage

// File: rtl/reg_read_port.sv
// reg_read_port: combinational read port with per-bit 8:1 data selection, write bypass and busy lookup.
module reg_read_port
    import reg_file_8x32_pkg::*;
#(
    parameter int W         = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic [NUM_REGS-1:0][W-1:0] regs,
    input  logic [NUM_REGS-1:0]        busy_vec,
    input  logic [REG_ADDR_W-1:0]      rd_addr,
    input  logic                       wr_en,
    input  logic [REG_ADDR_W-1:0]      wr_addr,
    input  logic [W-1:0]               wr_data,
    input  logic                       claim_en,
    input  logic [REG_ADDR_W-1:0]      claim_addr,
    output logic [W-1:0]               rd_data,
    output logic                       busy
);
    logic [W-1:0] stored;
    logic         wr_hit;
    logic         claim_hit;

    for (genvar b = 0; b < W; b++) begin : g_bit
        logic [NUM_REGS-1:0] col;
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
            assign col[r] = regs[r][b];
        end
        assign stored[b] = col[rd_addr];
    end

    assign wr_hit    = BYPASS_EN && wr_en && (wr_addr == rd_addr) && (wr_addr != ZERO_REG);
    assign claim_hit = claim_en && (claim_addr == rd_addr) && (claim_addr != ZERO_REG);
    assign rd_data   = wr_hit ? wr_data : stored;
    // A same-cycle write retires the pending producer unless a new one is claimed alongside it.
    assign busy      = (wr_hit && !claim_hit) ? 1'b0 : busy_vec[rd_addr];
endmodule

// File: rtl/reg_file_8x32.sv
// reg_file_8x32: 8x32 register file, one write port, two read ports, per-register busy scoreboard.
module reg_file_8x32
    import reg_file_8x32_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b,
    input  logic                  claim_en,
    input  logic [REG_ADDR_W-1:0] claim_addr,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic [NUM_REGS-1:0]   busy_vec
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;

    // Claim is applied after the write-clear so a new producer wins over the retiring one.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (claim_en) busy_d[claim_addr] = 1'b1;
        regs_d[ZERO_REG] = '0;
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    reg_read_port #(.W(DATA_W), .BYPASS_EN(BYPASS_EN)) u_port_a (
        .regs(regs_q), .busy_vec(busy_q), .rd_addr(rd_addr_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .rd_data(rd_data_a), .busy(busy_a)
    );

    reg_read_port #(.W(DATA_W), .BYPASS_EN(BYPASS_EN)) u_port_b (
        .regs(regs_q), .busy_vec(busy_q), .rd_addr(rd_addr_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .rd_data(rd_data_b), .busy(busy_b)
    );
endmodule

// File: tb/tb_reg_file_8x32.sv
// tb_reg_file_8x32: directed and model-checked stimulus for reg_file_8x32 with bypass on and off.
module tb_reg_file_8x32;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, claim_en;
    logic [2:0]  wr_addr, rd_addr_a, rd_addr_b, claim_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data_a, rd_data_b, rd_data_a0, rd_data_b0;
    logic        busy_a, busy_b, busy_a0, busy_b0;
    logic [7:0]  busy_vec, busy_vec0;
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] m_regs [8];
    logic [7:0]  m_busy;

    always #5 clk = ~clk;

    reg_file_8x32 #(.DATA_W(32), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_a(busy_a), .busy_b(busy_b), .busy_vec(busy_vec)
    );

    reg_file_8x32 #(.DATA_W(32), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a0), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b0),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_a(busy_a0), .busy_b(busy_b0), .busy_vec(busy_vec0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic slot();
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        claim_en = 1'b0;
    endtask

    task automatic model_check();
        logic [31:0] ea, eb;
        logic        wa, wb, ca, cb;
        wa = wr_en && wr_addr != 0 && wr_addr == rd_addr_a;
        wb = wr_en && wr_addr != 0 && wr_addr == rd_addr_b;
        ca = claim_en && claim_addr != 0 && claim_addr == rd_addr_a;
        cb = claim_en && claim_addr != 0 && claim_addr == rd_addr_b;
        ea = wa ? wr_data : m_regs[rd_addr_a];
        eb = wb ? wr_data : m_regs[rd_addr_b];
        check("rnd_rd_a", rd_data_a, ea);
        check("rnd_rd_b", rd_data_b, eb);
        check("rnd_busy_a", {31'd0, busy_a}, {31'd0, (wa && !ca) ? 1'b0 : m_busy[rd_addr_a]});
        check("rnd_busy_b", {31'd0, busy_b}, {31'd0, (wb && !cb) ? 1'b0 : m_busy[rd_addr_b]});
        check("rnd_busy_vec", {24'd0, busy_vec}, {24'd0, m_busy});
        check("rnd_nb_rd_a", rd_data_a0, m_regs[rd_addr_a]);
        check("rnd_nb_busy_a", {31'd0, busy_a0}, {31'd0, m_busy[rd_addr_a]});
        if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; claim_en = 1'b0;
        wr_addr = 3'd0; wr_data = '0; rd_addr_a = 3'd1; rd_addr_b = 3'd2; claim_addr = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_a", rd_data_a, 32'h0);
        check("reset_busy", {24'd0, busy_vec}, 32'h0);
        rst_n = 1'b1;
        for (int i = 1; i < 8; i++) begin
            slot();
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 32'hA5A5_0000 + i;
        end
        slot();
        claim_en = 1'b1; claim_addr = 3'd2;
        slot();
        rd_addr_a = 3'd5; rd_addr_b = 3'd7;
        #1;
        check("loaded_rd_a", rd_data_a, 32'hA5A5_0005);
        check("loaded_rd_b", rd_data_b, 32'hA5A5_0007);
        check("claimed_busy", {24'd0, busy_vec}, 32'h04);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rd_a", rd_data_a, 32'h0);
        check("async_rst_rd_b", rd_data_b, 32'h0);
        check("async_rst_busy", {24'd0, busy_vec}, 32'h0);
        #1 rst_n = 1'b1;

        slot();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'hDEAD_BEEF; rd_addr_a = 3'd5;
        slot();
        #1;
        check("wr5_rd_a", rd_data_a, 32'hDEAD_BEEF);
        check("wr5_nb_rd_a", rd_data_a0, 32'hDEAD_BEEF);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h1234; rd_addr_b = 3'd0;
        #1;
        check("wr0_bypass_rd_b", rd_data_b, 32'h0);
        slot();
        #1;
        check("wr0_rd_b", rd_data_b, 32'h0);

        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h55AA_55AA; rd_addr_a = 3'd3;
        #1;
        check("bypass_rd_a", rd_data_a, 32'h55AA_55AA);
        check("nobypass_old_rd_a", rd_data_a0, 32'h0);
        slot();
        #1;
        check("nobypass_new_rd_a", rd_data_a0, 32'h55AA_55AA);

        claim_en = 1'b1; claim_addr = 3'd4;
        slot();
        rd_addr_a = 3'd4;
        #1;
        check("claim4_busy_vec", {24'd0, busy_vec}, 32'h10);
        check("claim4_busy_a", {31'd0, busy_a}, 32'h1);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h4444;
        #1;
        check("wr4_bypass_busy_a", {31'd0, busy_a}, 32'h0);
        check("wr4_nobypass_busy_a", {31'd0, busy_a0}, 32'h1);
        slot();
        #1;
        check("wr4_busy_vec", {24'd0, busy_vec}, 32'h00);

        claim_en = 1'b1; claim_addr = 3'd6; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'h77;
        rd_addr_b = 3'd6;
        #1;
        check("cw6_bypass_rd_b", rd_data_b, 32'h77);
        slot();
        claim_en = 1'b1; claim_addr = 3'd0;
        #1;
        check("cw6_busy_vec", {24'd0, busy_vec}, 32'h40);
        check("cw6_rd_b", rd_data_b, 32'h77);
        check("cw6_busy_b", {31'd0, busy_b}, 32'h1);
        slot();
        #1;
        check("claim0_busy_vec", {24'd0, busy_vec}, 32'h40);

        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'hCAFE_F00D;
        slot();
        rd_addr_a = 3'd7; rd_addr_b = 3'd7;
        #1;
        check("dual_rd_a", rd_data_a, 32'hCAFE_F00D);
        check("dual_rd_b", rd_data_b, 32'hCAFE_F00D);
        check("dual_nb_rd_b", rd_data_b0, 32'hCAFE_F00D);

        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_busy = '0;
        for (int n = 0; n < 1000; n++) begin
            slot();
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = $urandom;
            claim_en   = 1'($urandom_range(0, 1));
            claim_addr = 3'($urandom_range(0, 7));
            rd_addr_a  = 3'($urandom_range(0, 7));
            rd_addr_b  = 3'($urandom_range(0, 7));
            #1;
            model_check();
        end
        slot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
